// File: rtl/axi_rd_master_if.sv
// Bus bundle for axi_rd_master: command input, AXI AR/R channels and read-data FIFO write side.
// The master modport is the axi_rd_master view; the slave modport is the environment view.
interface axi_rd_master_if #(
    parameter int P_AXI_DATA_WIDTH = 128,
    parameter int P_AXI_ADDR_WIDTH = 32,
    parameter int P_AXI_ID_WIDTH   = 4
);
    logic                        i_u2a_valid;
    logic [P_AXI_ADDR_WIDTH-1:0] i_u2a_addr;
    logic [7:0]                  i_u2a_length;
    logic                        o_axi_ready;

    logic [P_AXI_ID_WIDTH-1:0]   o_m_axi_arid;
    logic [P_AXI_ADDR_WIDTH-1:0] o_m_axi_araddr;
    logic [7:0]                  o_m_axi_arlen;
    logic [2:0]                  o_m_axi_arsize;
    logic [1:0]                  o_m_axi_arburst;
    logic                        o_m_axi_arvalid;
    logic                        i_m_axi_arready;

    logic [P_AXI_ID_WIDTH-1:0]   i_m_axi_rid;
    logic [P_AXI_DATA_WIDTH-1:0] i_m_axi_rdata;
    logic [1:0]                  i_m_axi_rresp;
    logic                        i_m_axi_rlast;
    logic                        i_m_axi_rvalid;
    logic                        o_m_axi_rready;

    logic                        i_fifo_full;
    logic                        i_fifo_almost_full;
    logic                        o_fifo_wr_en;
    logic [P_AXI_DATA_WIDTH-1:0] o_fifo_wr_data;

    modport master (
        input  i_u2a_valid, i_u2a_addr, i_u2a_length,
        output o_axi_ready,
        output o_m_axi_arid, o_m_axi_araddr, o_m_axi_arlen, o_m_axi_arsize,
        output o_m_axi_arburst, o_m_axi_arvalid,
        input  i_m_axi_arready,
        input  i_m_axi_rid, i_m_axi_rdata, i_m_axi_rresp, i_m_axi_rlast, i_m_axi_rvalid,
        output o_m_axi_rready,
        input  i_fifo_full, i_fifo_almost_full,
        output o_fifo_wr_en, o_fifo_wr_data
    );

    modport slave (
        output i_u2a_valid, i_u2a_addr, i_u2a_length,
        input  o_axi_ready,
        input  o_m_axi_arid, o_m_axi_araddr, o_m_axi_arlen, o_m_axi_arsize,
        input  o_m_axi_arburst, o_m_axi_arvalid,
        output i_m_axi_arready,
        output i_m_axi_rid, i_m_axi_rdata, i_m_axi_rresp, i_m_axi_rlast, i_m_axi_rvalid,
        input  o_m_axi_rready,
        output i_fifo_full, i_fifo_almost_full,
        input  o_fifo_wr_en, o_fifo_wr_data
    );
endinterface

// File: rtl/axi_rd_master.sv
// AXI4 read master: one outstanding INCR burst, R beats forwarded to the read-data FIFO.
// Optional watchdog enabled by defining AXI_RD_TIMEOUT_EN (adds o_err_timeout).
module axi_rd_master #(
    parameter int P_AXI_DATA_WIDTH = 128,
    parameter int P_AXI_ADDR_WIDTH = 32,
    parameter int P_AXI_ID_WIDTH   = 4,
    parameter int P_AXI_ID         = 0,
    parameter int P_TIMEOUT        = 1024
) (
    input  logic               i_clk,
    input  logic               i_rst,
    axi_rd_master_if.master    bus,
    output logic               o_err_resp,
    output logic               o_err_len,
    output logic               o_busy
`ifdef AXI_RD_TIMEOUT_EN
   ,output logic               o_err_timeout
`endif
);
    localparam int LP_ARSIZE = $clog2(P_AXI_DATA_WIDTH / 8);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_RDATA, S_END} state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [P_AXI_ADDR_WIDTH-1:0] r_addr;
    logic [7:0]                  r_len;
    logic [8:0]                  r_beats;
    logic                        r_wr_en;
    logic [P_AXI_DATA_WIDTH-1:0] r_wr_data;
    logic                        r_err_resp;
    logic                        w_ready;
    logic                        w_arvalid;
    logic                        w_rready;
    logic                        w_err_len;
    logic                        w_accept;
    logic                        w_beat;
    logic                        w_len_bad;
    logic                        w_tmo;

    assign bus.o_m_axi_arid    = P_AXI_ID_WIDTH'(P_AXI_ID);
    assign bus.o_m_axi_arsize  = 3'(LP_ARSIZE);
    assign bus.o_m_axi_arburst = 2'b01;
    assign bus.o_m_axi_araddr  = r_addr;
    assign bus.o_m_axi_arlen   = r_len;
    assign bus.o_m_axi_arvalid = w_arvalid;
    assign bus.o_m_axi_rready  = w_rready;
    assign bus.o_axi_ready     = w_ready;
    assign bus.o_fifo_wr_en    = r_wr_en;
    assign bus.o_fifo_wr_data  = r_wr_data;
    assign o_err_resp          = r_err_resp;
    assign o_err_len           = w_err_len;
    assign o_busy              = (r_state != S_IDLE);

    assign w_accept = w_ready && bus.i_u2a_valid;
    assign w_beat   = w_rready && bus.i_m_axi_rvalid;

`ifdef AXI_RD_TIMEOUT_EN
    localparam int LP_TW = $clog2(P_TIMEOUT + 1);

    logic [LP_TW-1:0] r_tmo_cnt;
    logic             r_err_timeout;
    logic             r_forced_end;

    assign w_tmo         = ((r_state == S_AR) || (r_state == S_RDATA)) &&
                           (r_tmo_cnt == LP_TW'(P_TIMEOUT - 1));
    assign w_len_bad     = !r_forced_end && (r_beats != ({1'b0, r_len} + 9'd1));
    assign o_err_timeout = r_err_timeout;

    // Watchdog: cycles since entering AR or since the last accepted beat.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tmo_cnt     <= {LP_TW{1'b0}};
            r_err_timeout <= 1'b0;
            r_forced_end  <= 1'b0;
        end else begin
            if (w_accept || w_beat) begin
                r_tmo_cnt <= {LP_TW{1'b0}};
            end else if ((r_state == S_AR) || (r_state == S_RDATA)) begin
                r_tmo_cnt <= r_tmo_cnt + LP_TW'(1);
            end
            r_err_timeout <= r_err_timeout | w_tmo;
            r_forced_end  <= w_tmo;
        end
    end
`else
    assign w_tmo     = 1'b0;
    assign w_len_bad = (r_beats != ({1'b0, r_len} + 9'd1));
`endif

    // Next-state and handshake decode; ready is held low while reset is asserted.
    always_comb begin
        w_next    = r_state;
        w_ready   = 1'b0;
        w_arvalid = 1'b0;
        w_rready  = 1'b0;
        w_err_len = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = !bus.i_fifo_almost_full && !i_rst;
                if (bus.i_u2a_valid && w_ready) w_next = S_AR;
                else                            w_next = S_IDLE;
            end
            S_AR: begin
                w_arvalid = 1'b1;
                if (bus.i_m_axi_arready) w_next = S_RDATA;
                else                     w_next = S_AR;
            end
            S_RDATA: begin
                w_rready = !bus.i_fifo_full;
                if (bus.i_m_axi_rvalid && w_rready && bus.i_m_axi_rlast) w_next = S_END;
                else                                                     w_next = S_RDATA;
            end
            S_END: begin
                w_err_len = w_len_bad;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_tmo) begin
            w_next    = S_END;
            w_arvalid = 1'b0;
            w_rready  = 1'b0;
        end else begin
            w_next = w_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_addr     <= {P_AXI_ADDR_WIDTH{1'b0}};
            r_len      <= 8'd0;
            r_beats    <= 9'd0;
            r_wr_en    <= 1'b0;
            r_wr_data  <= {P_AXI_DATA_WIDTH{1'b0}};
            r_err_resp <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wr_en <= w_beat;
            if (w_beat) r_wr_data <= bus.i_m_axi_rdata;
            if (w_accept) begin
                r_addr  <= bus.i_u2a_addr;
                r_len   <= bus.i_u2a_length;
                r_beats <= 9'd0;
            end else if (w_beat) begin
                r_beats <= r_beats + 9'd1;
            end
            if (w_beat && (bus.i_m_axi_rresp != 2'b00)) r_err_resp <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axi_rd_master.sv
// Directed testbench for axi_rd_master: bursts, back-to-back, backpressure, almost-full,
// error reporting, reset mid-burst and (with AXI_RD_TIMEOUT_EN) the watchdog.
module tb_axi_rd_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_resp, err_len, busy;
`ifdef AXI_RD_TIMEOUT_EN
    logic err_timeout;
    localparam int TB_TIMEOUT = 64;
`else
    localparam int TB_TIMEOUT = 1024;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ar_cnt  = 0;
    int errlen_cnt = 0;
    int wr_idx  = 0;
    logic [127:0] q_wr[$];
    logic [127:0] q_exp[$];
    int q_acc[$];

    axi_rd_master_if #(.P_AXI_DATA_WIDTH(128), .P_AXI_ADDR_WIDTH(32), .P_AXI_ID_WIDTH(4)) bus();

    axi_rd_master #(
        .P_AXI_DATA_WIDTH(128), .P_AXI_ADDR_WIDTH(32), .P_AXI_ID_WIDTH(4),
        .P_AXI_ID(0), .P_TIMEOUT(TB_TIMEOUT)
    ) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus),
        .o_err_resp(err_resp), .o_err_len(err_len), .o_busy(busy)
`ifdef AXI_RD_TIMEOUT_EN
       ,.o_err_timeout(err_timeout)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observe outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_fifo_wr_en) q_wr.push_back(bus.o_fifo_wr_data);
            if (bus.o_m_axi_arvalid && bus.i_m_axi_arready) ar_cnt <= ar_cnt + 1;
            if (bus.i_u2a_valid && bus.o_axi_ready) q_acc.push_back(cyc);
            if (err_len) errlen_cnt <= errlen_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pat(input logic [31:0] a, input int b);
        return {32'hDA7A_0000 + 32'(b), a, 32'(b * 7), ~a};
    endfunction

    task automatic verify_wr(input string tag);
        int n;
        chk({tag, "_nwr"}, 128'(q_wr.size()), 128'(q_exp.size()));
        n = (q_wr.size() < q_exp.size()) ? q_wr.size() : q_exp.size();
        for (int i = wr_idx; i < n; i++) chk({tag, "_data"}, q_wr[i], q_exp[i]);
        wr_idx = q_exp.size();
    endtask

    // One burst: command, AR after ar_dly cycles, nbeats beats (rlast on beat last_b).
    task automatic do_burst(input logic [31:0] addr, input logic [7:0] len, input int ar_dly,
                            input int nbeats, input int last_b, input int resp_b,
                            input bit tog_full, input bit pending, input bit hold,
                            input logic [31:0] naddr, input logic [7:0] nlen, input bit no_end);
        int k;
        int b;
        int guard;
        if (!pending) begin
            @(posedge clk); #1;
            bus.i_u2a_valid = 1'b1; bus.i_u2a_addr = addr; bus.i_u2a_length = len;
        end
        for (k = 0; k < 300; k++) begin
            if (bus.o_axi_ready) break;
            @(negedge clk);
        end
        if (k == 300) begin
            chk("accept_timeout", 128'(k), 128'(0));
            return;
        end
        @(posedge clk); #1;
        if (hold) begin bus.i_u2a_addr = naddr; bus.i_u2a_length = nlen; end
        else      bus.i_u2a_valid = 1'b0;
        for (int i = 0; i < nbeats; i++) q_exp.push_back(pat(addr, i));
        chk("arvalid_first", 128'(bus.o_m_axi_arvalid), 128'(1));
        repeat (ar_dly) begin @(posedge clk); #1; end
        bus.i_m_axi_arready = 1'b1;
        @(negedge clk);
        chk("arvalid_hs", 128'(bus.o_m_axi_arvalid), 128'(1));
        chk("araddr", 128'(bus.o_m_axi_araddr), 128'(addr));
        chk("arlen", 128'(bus.o_m_axi_arlen), 128'(len));
        chk("arsize", 128'(bus.o_m_axi_arsize), 128'(4));
        chk("arburst", 128'(bus.o_m_axi_arburst), 128'(1));
        @(posedge clk); #1;
        bus.i_m_axi_arready = 1'b0;
        chk("arvalid_drop", 128'(bus.o_m_axi_arvalid), 128'(0));
        b = 0; guard = 0;
        while (b < nbeats && guard < 4000) begin
            bus.i_m_axi_rvalid = 1'b1;
            bus.i_m_axi_rdata  = pat(addr, b);
            bus.i_m_axi_rlast  = (b == last_b);
            bus.i_m_axi_rresp  = (b == resp_b) ? 2'b10 : 2'b00;
            if (tog_full) bus.i_fifo_full = cyc[0];
            @(negedge clk);
            if (tog_full) chk("rready_mirror", 128'(bus.o_m_axi_rready), 128'(!bus.i_fifo_full));
            if (bus.o_m_axi_rready) b++;
            @(posedge clk); #1;
            guard++;
        end
        bus.i_m_axi_rvalid = 1'b0; bus.i_m_axi_rlast = 1'b0;
        bus.i_m_axi_rresp = 2'b00; bus.i_fifo_full = 1'b0;
        if (b < nbeats) chk("beat_timeout", 128'(b), 128'(nbeats));
        if (!no_end) begin
            for (k = 0; k < 20; k++) begin
                @(negedge clk);
                if (!busy) break;
            end
            chk("busy_idle", 128'(busy), 128'(0));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 128'(bus.o_axi_ready), 128'(0));
        chk({tag, "_arvalid"}, 128'(bus.o_m_axi_arvalid), 128'(0));
        chk({tag, "_araddr"}, 128'(bus.o_m_axi_araddr), 128'(0));
        chk({tag, "_arlen"}, 128'(bus.o_m_axi_arlen), 128'(0));
        chk({tag, "_arid"}, 128'(bus.o_m_axi_arid), 128'(0));
        chk({tag, "_rready"}, 128'(bus.o_m_axi_rready), 128'(0));
        chk({tag, "_wr_en"}, 128'(bus.o_fifo_wr_en), 128'(0));
        chk({tag, "_wr_data"}, bus.o_fifo_wr_data, 128'(0));
        chk({tag, "_err_resp"}, 128'(err_resp), 128'(0));
        chk({tag, "_err_len"}, 128'(err_len), 128'(0));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
    endtask

    initial begin
        int e0;
        int a0;
        int c0;
        bus.i_u2a_valid = 1'b0; bus.i_u2a_addr = 32'h0; bus.i_u2a_length = 8'd0;
        bus.i_m_axi_arready = 1'b0; bus.i_m_axi_rid = 4'd0; bus.i_m_axi_rdata = 128'd0;
        bus.i_m_axi_rresp = 2'b00; bus.i_m_axi_rlast = 1'b0; bus.i_m_axi_rvalid = 1'b0;
        bus.i_fifo_full = 1'b0; bus.i_fifo_almost_full = 1'b0;
        #2;
        chk_reset_outputs("rst");
        chk("rst_arsize", 128'(bus.o_m_axi_arsize), 128'(4));
        chk("rst_arburst", 128'(bus.o_m_axi_arburst), 128'(1));
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single 256-beat burst.
        e0 = errlen_cnt;
        do_burst(32'h1000, 8'd255, 3, 256, 255, -1, 1'b0, 1'b0, 1'b0, 32'h0, 8'd0, 1'b0);
        verify_wr("single");
        chk("single_errlen", 128'(errlen_cnt - e0), 128'(0));
        chk("single_errresp", 128'(err_resp), 128'(0));

        // Back-to-back with valid held high.
        a0 = ar_cnt; c0 = q_acc.size();
        do_burst(32'h0, 8'd255, 3, 256, 255, -1, 1'b0, 1'b0, 1'b1, 32'h1000, 8'd255, 1'b0);
        do_burst(32'h1000, 8'd255, 3, 256, 255, -1, 1'b0, 1'b1, 1'b0, 32'h0, 8'd0, 1'b0);
        verify_wr("b2b");
        chk("b2b_ar_cnt", 128'(ar_cnt - a0), 128'(2));
        chk("b2b_acc_cnt", 128'(q_acc.size() - c0), 128'(2));
        if (q_acc.size() >= c0 + 2) chk("b2b_gap", 128'(q_acc[c0 + 1] - q_acc[c0]), 128'(262));

        // FIFO backpressure toggling every other cycle.
        do_burst(32'h3000, 8'd15, 1, 16, 15, -1, 1'b1, 1'b0, 1'b0, 32'h0, 8'd0, 1'b0);
        verify_wr("bp");

        // Almost-full blocks acceptance; release accepts on the next cycle.
        a0 = ar_cnt;
        @(posedge clk); #1;
        bus.i_fifo_almost_full = 1'b1; bus.i_u2a_valid = 1'b1;
        bus.i_u2a_addr = 32'h2000; bus.i_u2a_length = 8'd3;
        repeat (5) begin
            @(negedge clk);
            chk("afull_ready", 128'(bus.o_axi_ready), 128'(0));
            chk("afull_arvalid", 128'(bus.o_m_axi_arvalid), 128'(0));
        end
        @(posedge clk); #1;
        bus.i_fifo_almost_full = 1'b0;
        c0 = cyc;
        do_burst(32'h2000, 8'd3, 0, 4, 3, -1, 1'b0, 1'b1, 1'b0, 32'h0, 8'd0, 1'b0);
        verify_wr("afull");
        chk("afull_ar_cnt", 128'(ar_cnt - a0), 128'(1));
        if (q_acc.size() > 0) chk("afull_acc_cycle", 128'(q_acc[q_acc.size() - 1]), 128'(c0));

        // Short burst (rlast on beat 10 of 16) with SLVERR on beat 3.
        e0 = errlen_cnt;
        do_burst(32'h4000, 8'd15, 2, 10, 9, 2, 1'b0, 1'b0, 1'b0, 32'h0, 8'd0, 1'b0);
        verify_wr("short");
        chk("short_errlen_pulse", 128'(errlen_cnt - e0), 128'(1));
        chk("short_errresp", 128'(err_resp), 128'(1));

        // Clean burst: err_resp stays sticky, no new length error.
        e0 = errlen_cnt;
        do_burst(32'h5000, 8'd1, 0, 2, 1, -1, 1'b0, 1'b0, 1'b0, 32'h0, 8'd0, 1'b0);
        verify_wr("clean");
        chk("clean_errlen", 128'(errlen_cnt - e0), 128'(0));
        chk("sticky_errresp", 128'(err_resp), 128'(1));

        // Reset after 5 beats of a 16-beat burst.
        do_burst(32'h6000, 8'd15, 0, 5, 99, -1, 1'b0, 1'b0, 1'b0, 32'h0, 8'd0, 1'b1);
        @(negedge clk);
        chk("pre_rst_busy", 128'(busy), 128'(1));
        @(posedge clk); #1;
        bus.i_m_axi_rvalid = 1'b1; bus.i_m_axi_rdata = pat(32'h6000, 5);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk); #1;
        rst = 1'b0; bus.i_m_axi_rvalid = 1'b0;
        verify_wr("midrst");
        do_burst(32'h7000, 8'd0, 0, 1, 0, -1, 1'b0, 1'b0, 1'b0, 32'h0, 8'd0, 1'b0);
        verify_wr("recover");

`ifdef AXI_RD_TIMEOUT_EN
        chk("to_initial", 128'(err_timeout), 128'(0));
        @(posedge clk); #1;
        bus.i_u2a_valid = 1'b1; bus.i_u2a_addr = 32'h8000; bus.i_u2a_length = 8'd7;
        @(negedge clk);
        c0 = cyc;
        chk("to_ready", 128'(bus.o_axi_ready), 128'(1));
        @(posedge clk); #1;
        bus.i_u2a_valid = 1'b0;
        a0 = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (err_timeout) begin a0 = cyc; break; end
        end
        chk("to_seen", 128'(err_timeout), 128'(1));
        chk("to_gap", 128'(a0 - c0), 128'(65));
        chk("to_arvalid", 128'(bus.o_m_axi_arvalid), 128'(0));
        @(negedge clk);
        chk("to_idle", 128'(busy), 128'(0));
        chk("to_sticky", 128'(err_timeout), 128'(1));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_rd_master.md
Name: axi_rd_master

Overview:
- AXI4 read master stage directly downstream of the read-request controller.
- Accepts one burst command (address, length) per valid/ready handshake and issues it on the AR channel.
- Collects the R beats and writes them into the read-data FIFO.
- Tracks one outstanding burst at a time and reports protocol errors (bad RRESP, beat count not matching length).

Parameters:
- P_AXI_DATA_WIDTH, 128, R data width in bits; power of two, 32 to 1024.
- P_AXI_ADDR_WIDTH, 32, AR address width.
- P_AXI_ID_WIDTH, 4, ARID/RID width.
- P_AXI_ID, 0, constant ARID driven on every burst.
- P_TIMEOUT, 1024, watchdog limit in cycles; used only with the optional feature.

Ports:
- i_clk  in  1  single clock for all logic.
- i_rst  in  1  reset, asynchronous, active-high.
- i_u2a_valid  in  1  command valid from the request controller.
- i_u2a_addr  in  P_AXI_ADDR_WIDTH  burst start address.
- i_u2a_length  in  8  AXI ARLEN value (beats minus 1).
- o_axi_ready  out  1  command accept.
- o_m_axi_arid  out  P_AXI_ID_WIDTH  ARID.
- o_m_axi_araddr  out  P_AXI_ADDR_WIDTH  ARADDR.
- o_m_axi_arlen  out  8  ARLEN.
- o_m_axi_arsize  out  3  ARSIZE.
- o_m_axi_arburst  out  2  ARBURST.
- o_m_axi_arvalid  out  1  ARVALID.
- i_m_axi_arready  in  1  ARREADY.
- i_m_axi_rid  in  P_AXI_ID_WIDTH  RID; ignored.
- i_m_axi_rdata  in  P_AXI_DATA_WIDTH  RDATA.
- i_m_axi_rresp  in  2  RRESP.
- i_m_axi_rlast  in  1  RLAST.
- i_m_axi_rvalid  in  1  RVALID.
- o_m_axi_rready  out  1  RREADY.
- i_fifo_full  in  1  read-data FIFO full.
- i_fifo_almost_full  in  1  FIFO cannot absorb another full burst.
- o_fifo_wr_en  out  1  FIFO write strobe.
- o_fifo_wr_data  out  P_AXI_DATA_WIDTH  FIFO write data.
- o_err_resp  out  1  sticky: RRESP != OKAY seen.
- o_err_len  out  1  1-cycle pulse: beat count differs from ARLEN+1.
- o_busy  out  1  burst in flight.

Behaviour:
- Reset values: every output 0, except o_m_axi_arsize and o_m_axi_arburst, which are constants.
- Asserting i_rst mid-burst returns the block to IDLE immediately. Any AXI burst in flight is abandoned, because the slave shares the same reset.
- Constants:
  - o_m_axi_arsize = log2(P_AXI_DATA_WIDTH/8), which is 4 at the default width.
  - o_m_axi_arburst = 2'b01 (INCR).
  - o_m_axi_arid = P_AXI_ID.
- FSM states: IDLE, AR, RDATA, END.
  - IDLE: o_axi_ready = !i_fifo_almost_full (combinational). On i_u2a_valid && o_axi_ready, latch addr/length, clear the beat counter and go to AR.
  - AR: o_m_axi_arvalid = 1 from the first cycle in AR. araddr/arlen hold the latched values and stay stable until i_m_axi_arready. On handshake, arvalid drops next cycle and the FSM goes to RDATA.
  - RDATA: o_m_axi_rready = !i_fifo_full (combinational); it is 0 in every other state. Each beat (rvalid && rready) produces:
    - o_fifo_wr_en = 1 and o_fifo_wr_data = rdata on the next cycle (1-cycle registered latency, one write per beat, no drops);
    - a 9-bit beat counter increment.
    - A beat carrying rlast moves the FSM to END.
  - END: single cycle. If the final beat count != length+1, pulse o_err_len; the count is checked once per burst, on rlast. Then go to IDLE.
- o_busy = (state != IDLE).
- o_axi_ready is 0 outside IDLE. A new command is therefore accepted no earlier than the cycle after END: minimum 4 cycles between command handshakes (accept, AR, ≥1 beat, END).
- Beats beyond length+1 before rlast are still written to the FIFO; the mismatch is flagged in END.
- RRESP != 0 on any accepted beat sets o_err_resp. It stays set until i_rst.
- When rvalid and fifo_full coincide, rready is 0, the beat is not consumed and the slave holds it.
- i_fifo_almost_full is sampled only in IDLE. The FIFO owner sizes almost-full so that a full 256-beat burst always fits.

Optional Feature:
- AXI_RD_TIMEOUT_EN defined:
  - Adds a cycle counter, reset on entry to AR and on every accepted R beat.
  - If the counter reaches P_TIMEOUT while in AR or RDATA, the FSM forces END and asserts the extra output o_err_timeout (sticky until i_rst), and arvalid/rready drop.
- AXI_RD_TIMEOUT_EN undefined: no counter, no o_err_timeout port, and the FSM waits indefinitely.

Test Plan:
- Single burst: i_u2a_addr=0x1000, length=255, arready after 3 cycles, 256 continuous beats with rlast on beat 256 -> araddr=0x1000, arlen=255, arsize=4, arburst=1, 256 FIFO writes in order, o_err_len=0, o_busy back to 0 after END.
- Back-to-back: valid held high with addresses 0x0, 0x1000 -> second accept no earlier than the cycle after the first END; two AR handshakes, 512 writes.
- Backpressure: i_fifo_full toggled every other cycle during a 16-beat burst (length=15) -> rready mirrors !full, exactly 16 writes, data order preserved.
- Almost-full: i_fifo_almost_full=1 with i_u2a_valid=1 -> o_axi_ready=0 and no AR. Deassert it -> accept on the next cycle.
- Errors: rlast on beat 10 for length=15 -> o_err_len pulses 1 cycle in END. RRESP=2'b10 on beat 3 -> o_err_resp=1 held until reset.
- Reset mid-RDATA after 5 beats -> all outputs 0 and state IDLE immediately. With AXI_RD_TIMEOUT_EN and P_TIMEOUT=64, arready held 0 -> o_err_timeout after 64 cycles, then IDLE.
